// File: rtl/shifter_pkg.sv
// Shared encodings for the registered 8-bit shifter and its sequencer.
// Select codes, sequencer states and the shift-direction bit.
package shifter_pkg;

  localparam int DATA_W = 8;
  localparam int AMT_W  = $clog2(DATA_W);

  localparam logic [1:0] SH_HOLD  = 2'b00;
  localparam logic [1:0] SH_RIGHT = 2'b01;
  localparam logic [1:0] SH_LEFT  = 2'b10;
  localparam logic [1:0] SH_LOAD  = 2'b11;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LOAD   = 2'b01,
    SHIFT  = 2'b10,
    SETTLE = 2'b11
  } state_t;

endpackage

// File: rtl/shifter.sv
// Registered 8-bit shifter in the datapath: hold, logical right/left, load.
// flag captures the bit that drops off so[0] on a right shift and is otherwise left alone.
module shifter
  import shifter_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        s,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] so,
  output logic              flag
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      so   <= '0;
      flag <= 1'b0;
    end else begin
      case (s)
        SH_RIGHT: begin
          so   <= {1'b0, so[DATA_W-1:1]};
          flag <= so[0];
        end
        SH_LEFT:  so <= {so[DATA_W-2:0], 1'b0};
        SH_LOAD:  so <= din;
        default:  ;
      endcase
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// Sequences one shift command on the datapath shifter: a load cycle, N shift cycles, a settle cycle.
// Returns the shifted value and carry-out with a busy/done handshake.
module shift_sequencer
  import shifter_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int AMT_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              dir,
  input  logic [AMT_W-1:0]  amount,
  input  logic [DATA_W-1:0] operand,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic [1:0]        sh_s,
  output logic [DATA_W-1:0] sh_din,
  input  logic [DATA_W-1:0] sh_so,
  input  logic              sh_flag
);

  state_t              state, state_d;
  logic [DATA_W-1:0]   op_q;
  logic                dir_q;
  logic [AMT_W-1:0]    cnt;
  logic                amt_zero_q;
  logic                carry_l;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      op_q       <= '0;
      dir_q      <= 1'b0;
      cnt        <= '0;
      amt_zero_q <= 1'b0;
      carry_l    <= 1'b0;
      result     <= '0;
      carry      <= 1'b0;
      done       <= 1'b0;
    end else begin
      state <= state_d;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q       <= operand;
            dir_q      <= dir;
            cnt        <= amount;
            amt_zero_q <= (amount == '0);
            carry_l    <= 1'b0;
          end
        end
        SHIFT: begin
          cnt <= cnt - 1'b1;
          if (dir_q == DIR_LEFT) carry_l <= sh_so[DATA_W-1];
        end
        SETTLE: begin
          result <= sh_so;
          // The shifter flag is stale after a load or left shift, so it is only trusted for right shifts.
          if (amt_zero_q)              carry <= 1'b0;
          else if (dir_q == DIR_RIGHT) carry <= sh_flag;
          else                         carry <= carry_l;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state;
    sh_s    = SH_HOLD;
    sh_din  = '0;
    case (state)
      IDLE: begin
        if (start) state_d = LOAD;
      end
      LOAD: begin
        sh_s    = SH_LOAD;
        sh_din  = op_q;
        state_d = (cnt != '0) ? SHIFT : SETTLE;
      end
      SHIFT: begin
        sh_s = (dir_q == DIR_RIGHT) ? SH_RIGHT : SH_LEFT;
        if (cnt == AMT_W'(1)) state_d = SETTLE;
      end
      SETTLE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule
